// File: rtl/logicunit_seq.sv
// Registered AND/OR/NOR/XOR unit with accumulator and output FIFO.
// Define LU_FLAGS_EN to store a zero flag per entry and expose out_zero.
module logicunit_seq #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_A,
    input  logic [WIDTH-1:0]             in_B,
    input  logic [2:0]                   in_control,
    input  logic                         acc_clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
`ifdef LU_FLAGS_EN
    output logic                         out_zero,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
`ifdef LU_FLAGS_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [EW-1:0]    head_q, head_d;

    logic             accept, pop;
    logic [WIDTH-1:0] a_eff, result;
    logic [EW-1:0]    entry;
    logic [PW-1:0]    rd_next;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign rd_next   = rd_ptr_q + PW'(1);

    assign out_data  = head_q[WIDTH-1:0];
`ifdef LU_FLAGS_EN
    assign out_zero  = head_q[WIDTH];
    assign entry     = {(result == '0), result};
`else
    assign entry     = result;
`endif

    // acc_clear wins over the stored value before it can feed an accumulate op
    always_comb begin
        a_eff = in_control[2] ? (acc_clear ? '0 : acc_q) : in_A;
        result = '0;
        unique case (in_control[1:0])
            2'd0: result = a_eff & in_B;
            2'd1: result = a_eff | in_B;
            2'd2: result = ~(a_eff | in_B);
            2'd3: result = a_eff ^ in_B;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        head_d   = head_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            acc_d    = result;
        end else if (acc_clear) begin
            acc_d = '0;
        end
        if (pop)
            rd_ptr_d = rd_next;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // head register tracks the next head entry and holds when drained
        if (accept && (count_q == '0 || (pop && count_q == CW'(1))))
            head_d = entry;
        else if (pop && count_q > CW'(1))
            head_d = mem_q[rd_next];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && accept)
            mem_q[wr_ptr_q] <= entry;
    end

endmodule

// File: tb/tb_logicunit_seq.sv
// Randomized bench for logicunit_seq against a queue-based reference model.
module tb_logicunit_seq;

    localparam int W = 8;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_A, in_B;
    logic [2:0]   in_control;
    logic         acc_clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   count;
`ifdef LU_FLAGS_EN
    logic         out_zero;
`endif

    logic [W-1:0] mq[$];
    logic [W-1:0] m_acc;
    logic [W-1:0] m_last;
    int           passed = 0;
    int           total  = 0;

    logicunit_seq #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_control(in_control),
        .acc_clear(acc_clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
`ifdef LU_FLAGS_EN
        .out_zero(out_zero),
`endif
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] c,
            input logic [W-1:0] a, input logic [W-1:0] b,
            input logic [W-1:0] acc, input logic clr);
        logic [W-1:0] x;
        x = c[2] ? (clr ? 8'h00 : acc) : a;
        case (c[1:0])
            2'd0: return x & b;
            2'd1: return x | b;
            2'd2: return 8'hFF ^ (x | b);
            default: return x ^ b;
        endcase
    endfunction

    task automatic compare();
        chk("out_valid", int'(out_valid), int'(mq.size() != 0));
        chk("in_ready", int'(in_ready), int'(mq.size() != D));
        chk("count", int'(count), mq.size());
        chk("out_data", int'(out_data), int'(mq.size() != 0 ? mq[0] : m_last));
`ifdef LU_FLAGS_EN
        if (mq.size() != 0)
            chk("out_zero", int'(out_zero), int'(mq[0] == 0));
`endif
    endtask

    // advance model by one edge from current inputs, then check at negedge
    task automatic tick();
        logic acc_ok, pop_ok;
        logic [W-1:0] r;
        if (reset) begin
            mq.delete();
            m_acc  = '0;
            m_last = '0;
        end else begin
            acc_ok = in_valid && (mq.size() < D);
            pop_ok = out_ready && (mq.size() > 0);
            r = ref_op(in_control, in_A, in_B, m_acc, acc_clear);
            if (pop_ok) void'(mq.pop_front());
            if (acc_ok) begin
                mq.push_back(r);
                m_acc = r;
            end else if (acc_clear) begin
                m_acc = '0;
            end
            if (mq.size() != 0) m_last = mq[0];
        end
        @(posedge clock);
        @(negedge clock);
        compare();
    endtask

    task automatic drive(input logic v, input logic [2:0] c,
            input logic [W-1:0] a, input logic [W-1:0] b, input logic clr);
        in_valid = v; in_control = c; in_A = a; in_B = b; acc_clear = clr;
    endtask

    initial begin
        logic [W-1:0] exp2 [4];
        logic [W-1:0] exp3 [4];
        logic [2:0]   ctl3 [4];
        logic [W-1:0] a3   [4];
        logic [W-1:0] b3   [4];
        logic         c3   [4];
        exp2 = '{8'h30, 8'hFC, 8'h03, 8'hCC};
        exp3 = '{8'h0F, 8'hF0, 8'hF1, 8'h05};
        ctl3 = '{3'b011, 3'b111, 3'b101, 3'b101};
        a3   = '{8'h0F, 8'hAA, 8'h55, 8'h99};
        b3   = '{8'h00, 8'hFF, 8'h01, 8'h05};
        c3   = '{1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; out_ready = 1'b0;
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        tick(); tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_data", int'(out_data), 0);
        reset = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i), 8'hF0, 8'h3C, 1'b0);
            tick();
            chk("op_data", int'(out_data), int'(exp2[i]));
            chk("op_count_le1", int'(count <= 3'd1), 1);
        end
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        tick();

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ctl3[i], a3[i], b3[i], c3[i]);
            tick();
            chk("acc_data", int'(out_data), int'(exp3[i]));
        end
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        tick();

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i % 4), 8'(8'h11 * i + 3), 8'(8'h2D + i), 1'b0);
            if (i == 4) begin
                tick();
            end else begin
                tick();
            end
        end
        chk("full_count", int'(count), 4);
        chk("full_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        tick();
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) tick();

        out_ready = 1'b0;
        drive(1'b1, 3'b001, 8'h12, 8'h40, 1'b0); tick();
        drive(1'b1, 3'b011, 8'h34, 8'h0F, 1'b0); tick();
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 8'hFE, 8'h7F, 1'b0); tick();
        chk("simul_count", int'(count), 2);
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 8'h01, 8'h02, 1'b0); tick();
        chk("pre_rst_count", int'(count), 3);
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("rst_mid_count", int'(count), 0);
        chk("rst_mid_valid", int'(out_valid), 0);
        out_ready = 1'b1;
        drive(1'b1, 3'b101, 8'hAA, 8'h00, 1'b0); tick();
        chk("rst_acc_zero", int'(out_data), 0);

        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 149) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 2) != 0), 3'($urandom),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
            if (n % 500 < 60) out_ready = 1'b0;
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
